sha256_compress: RTL and testbench



---
 rtl/sha256_pkg.sv | 49 ++++
 rtl/sha256_compress_if.sv | 23 ++
 rtl/sha256_funcs.sv | 40 ++++
 rtl/sha256_sched.sv | 40 ++++
 rtl/sha256_compress.sv | 135 +++++++++++++
 tb/tb_sha256_compress.sv | 204 ++++++++++++++++++++
 6 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, types and small bit-mixing helpers.
// Consumers select the optional feed-forward add with SHA256_FEEDFORWARD_EN.
package sha256_pkg;

    localparam int unsigned ROUNDS = 64;
    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0]       word_t;
    typedef logic [0:7][WORD_W-1:0]  hash_t;
    typedef logic [0:15][WORD_W-1:0] block_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam word_t IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic word_t rotr(input word_t x, input logic [4:0] n);
        return (x >> n) | (x << (6'd32 - {1'b0, n}));
    endfunction

    function automatic word_t ssig0(input word_t x);
        return rotr(x, 5'd7) ^ rotr(x, 5'd18) ^ (x >> 5'd3);
    endfunction

    function automatic word_t ssig1(input word_t x);
        return rotr(x, 5'd17) ^ rotr(x, 5'd19) ^ (x >> 5'd10);
    endfunction

endpackage

// File: rtl/sha256_compress_if.sv
// Block-in / digest-out handshake bundle between the packer, the engine and the nonce controller.
interface sha256_compress_if;

    logic         in_valid;
    logic         in_ready;
    logic [511:0] block_in;
    logic [255:0] h_in;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] digest;
    logic         busy;

    modport master (
        output in_valid, block_in, h_in, out_ready,
        input  in_ready, out_valid, digest, busy
    );

    modport slave (
        input  in_valid, block_in, h_in, out_ready,
        output in_ready, out_valid, digest, busy
    );

endinterface

// File: rtl/sha256_funcs.sv
// Combinational round-function blocks: big-sigma 0/1, choose and majority.
module sha256_bsig0
    import sha256_pkg::*;
(
    input  word_t x,
    output word_t y
);
    assign y = rotr(x, 5'd2) ^ rotr(x, 5'd13) ^ rotr(x, 5'd22);
endmodule

module sha256_bsig1
    import sha256_pkg::*;
(
    input  word_t x,
    output word_t y
);
    assign y = rotr(x, 5'd6) ^ rotr(x, 5'd11) ^ rotr(x, 5'd25);
endmodule

module sha256_ch
    import sha256_pkg::*;
(
    input  word_t e,
    input  word_t f,
    input  word_t g,
    output word_t y
);
    assign y = (e & f) ^ (~e & g);
endmodule

module sha256_maj
    import sha256_pkg::*;
(
    input  word_t a,
    input  word_t b,
    input  word_t c,
    output word_t y
);
    assign y = (a & b) ^ (a & c) ^ (b & c);
endmodule

// File: rtl/sha256_sched.sv
// Message schedule: 16-word sliding window whose head is always W_t.
module sha256_sched
    import sha256_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   shift,
    input  block_t block_in,
    output word_t  w_t
);
    block_t win_q, win_d;
    word_t  w_next_s;

    // Window holds W_t..W_t+15, so the appended word is W_t+16.
    assign w_next_s = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];
    assign w_t      = win_q[0];

    // Next-window selection: load a fresh block, advance one word, or hold.
    always_comb begin
        win_d = win_q;
        if (load) begin
            win_d = block_in;
        end else if (shift) begin
            win_d = {win_q[1:15], w_next_s};
        end else begin
            win_d = win_q;
        end
    end

    // Window register.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end

endmodule

// File: rtl/sha256_compress.sv
// Iterative SHA-256 compression, one round per clock.
// Define SHA256_FEEDFORWARD_EN to fold the chaining value into the digest in a FINAL state.
module sha256_compress
    import sha256_pkg::*;
(
    input logic              clk,
    input logic              rst,
    sha256_compress_if.slave bus
);
    state_e     state_q, state_d;
    logic [5:0] t_q, t_d;
    hash_t      wv_q, wv_d;
    hash_t      digest_q, digest_d;
`ifdef SHA256_FEEDFORWARD_EN
    hash_t      hreg_q, hreg_d;
`endif
    logic       in_ready_q, out_valid_q, busy_q;
    logic       load_s, shift_s;
    word_t      w_t_s, bsig0_s, bsig1_s, ch_s, maj_s, t1_s, t2_s;
    hash_t      wv_next_s;

    sha256_sched u_sched (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .shift    (shift_s),
        .block_in (bus.block_in),
        .w_t      (w_t_s)
    );

    sha256_bsig0 u_bsig0 (.x(wv_q[0]), .y(bsig0_s));
    sha256_bsig1 u_bsig1 (.x(wv_q[4]), .y(bsig1_s));
    sha256_ch    u_ch    (.e(wv_q[4]), .f(wv_q[5]), .g(wv_q[6]), .y(ch_s));
    sha256_maj   u_maj   (.a(wv_q[0]), .b(wv_q[1]), .c(wv_q[2]), .y(maj_s));

    // Working variables are a..h at indices 0..7.
    assign t1_s      = wv_q[7] + bsig1_s + ch_s + K[t_q] + w_t_s;
    assign t2_s      = bsig0_s + maj_s;
    assign wv_next_s = {t1_s + t2_s, wv_q[0], wv_q[1], wv_q[2],
                        wv_q[3] + t1_s, wv_q[4], wv_q[5], wv_q[6]};

    // Sequencing and next-state datapath.
    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        wv_d     = wv_q;
        digest_d = digest_q;
        load_s   = 1'b0;
        shift_s  = 1'b0;
`ifdef SHA256_FEEDFORWARD_EN
        hreg_d   = hreg_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    load_s  = 1'b1;
                    wv_d    = bus.h_in;
                    t_d     = 6'd0;
                    state_d = ROUND;
`ifdef SHA256_FEEDFORWARD_EN
                    hreg_d  = bus.h_in;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            ROUND: begin
                shift_s = 1'b1;
                wv_d    = wv_next_s;
                t_d     = t_q + 6'd1;
                if (t_q == LAST_ROUND) begin
`ifdef SHA256_FEEDFORWARD_EN
                    state_d  = FINAL;
`else
                    digest_d = wv_next_s;
                    state_d  = DONE;
`endif
                end else begin
                    state_d = ROUND;
                end
            end
            FINAL: begin
`ifdef SHA256_FEEDFORWARD_EN
                for (int i = 0; i < 8; i++) begin
                    digest_d[i] = hreg_q[i] + wv_q[i];
                end
`endif
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and handshake-output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            t_q         <= 6'd0;
            wv_q        <= '0;
            digest_q    <= '0;
`ifdef SHA256_FEEDFORWARD_EN
            hreg_q      <= '0;
`endif
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            wv_q        <= wv_d;
            digest_q    <= digest_d;
`ifdef SHA256_FEEDFORWARD_EN
            hreg_q      <= hreg_d;
`endif
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.digest    = digest_q;

endmodule

// File: tb/tb_sha256_compress.sv
// Directed bench for sha256_compress; expectations follow SHA256_FEEDFORWARD_EN.
module tb_sha256_compress;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    sha256_compress_if bus_if ();

    sha256_compress dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SHA256_FEEDFORWARD_EN
    localparam int LAT_EXP = 65;
`else
    localparam int LAT_EXP = 64;
`endif

    localparam logic [255:0] IV_C = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC_D = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMPTY_D = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] MID_D = 256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;
    localparam logic [255:0] TWO_D = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    localparam logic [511:0] ABC_B = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_B = {32'h80000000, 480'h0};
    localparam logic [511:0] TWO_B1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_B2 = {480'h0, 32'h000001c0};

    // Without feed-forward the engine returns the full digest minus the chaining value.
    function automatic logic [255:0] exp_out(input logic [255:0] full, input logic [255:0] h);
        logic [255:0] r;
        r = full;
`ifndef SHA256_FEEDFORWARD_EN
        for (int i = 0; i < 8; i++) begin
            r[i*32 +: 32] = full[i*32 +: 32] - h[i*32 +: 32];
        end
`endif
        return r;
    endfunction

    task automatic run_block(input logic [511:0] blk, input logic [255:0] h,
                             output logic [255:0] dig, output int lat);
        bus_if.block_in  = blk;
        bus_if.h_in      = h;
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b0;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        lat = 0;
        while (bus_if.out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        dig = bus_if.digest;
    endtask

    task automatic take_digest();
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        total++; if (bus_if.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus_if.in_ready); end
        total++; if (bus_if.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus_if.out_valid); end
        total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus_if.busy); end
        total++; if (bus_if.digest !== 256'h0) begin bad++; $display("FAIL reset_digest got=%h exp=0", bus_if.digest); end
    endtask

    task automatic test_abc();
        logic [255:0] dig;
        int lat;
        run_block(ABC_B, IV_C, dig, lat);
        total++; if (lat !== LAT_EXP) begin bad++; $display("FAIL abc_latency got=%0d exp=%0d", lat, LAT_EXP); end
        total++; if (dig !== exp_out(ABC_D, IV_C)) begin bad++; $display("FAIL abc_digest got=%h exp=%h", dig, exp_out(ABC_D, IV_C)); end
        total++; if (bus_if.in_ready !== 1'b0) begin bad++; $display("FAIL abc_ready_in_done got=%b exp=0", bus_if.in_ready); end
        take_digest();
        total++; if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0) begin
            bad++; $display("FAIL abc_after_take in_ready=%b out_valid=%b exp 1/0", bus_if.in_ready, bus_if.out_valid);
        end
    endtask

    task automatic test_empty();
        logic [255:0] dig;
        int lat;
        run_block(EMPTY_B, IV_C, dig, lat);
        total++; if (dig !== exp_out(EMPTY_D, IV_C)) begin bad++; $display("FAIL empty_digest got=%h exp=%h", dig, exp_out(EMPTY_D, IV_C)); end
        take_digest();
    endtask

    task automatic test_two_block();
        logic [255:0] dig;
        int lat;
        run_block(TWO_B1, IV_C, dig, lat);
        total++; if (dig !== exp_out(MID_D, IV_C)) begin bad++; $display("FAIL two_block1 got=%h exp=%h", dig, exp_out(MID_D, IV_C)); end
        take_digest();
        run_block(TWO_B2, MID_D, dig, lat);
        total++; if (dig !== exp_out(TWO_D, MID_D)) begin bad++; $display("FAIL two_block2 got=%h exp=%h", dig, exp_out(TWO_D, MID_D)); end
        take_digest();
    endtask

    task automatic test_backpressure();
        logic [255:0] dig;
        int lat;
        run_block(ABC_B, IV_C, dig, lat);
        bus_if.block_in = EMPTY_B;
        for (int i = 0; i < 20; i++) begin
            bus_if.in_valid = (i % 3 == 0);
            @(posedge clk); #1;
            total++; if (bus_if.digest !== exp_out(ABC_D, IV_C) || bus_if.in_ready !== 1'b0 || bus_if.out_valid !== 1'b1) begin
                bad++; $display("FAIL bp_hold cyc=%0d digest=%h in_ready=%b out_valid=%b", i, bus_if.digest, bus_if.in_ready, bus_if.out_valid);
            end
        end
        bus_if.in_valid = 1'b0;
        take_digest();
        @(posedge clk); #1;
        total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL bp_no_accept busy=%b exp=0", bus_if.busy); end
    endtask

    task automatic test_reset_mid();
        logic [255:0] dig;
        int lat;
        bus_if.block_in = ABC_B;
        bus_if.h_in     = IV_C;
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0 || bus_if.busy !== 1'b0) begin
            bad++; $display("FAIL midrst_ctrl in_ready=%b out_valid=%b busy=%b exp 1/0/0", bus_if.in_ready, bus_if.out_valid, bus_if.busy);
        end
        total++; if (bus_if.digest !== 256'h0) begin bad++; $display("FAIL midrst_digest got=%h exp=0", bus_if.digest); end
        run_block(ABC_B, IV_C, dig, lat);
        total++; if (dig !== exp_out(ABC_D, IV_C)) begin bad++; $display("FAIL midrst_rerun got=%h exp=%h", dig, exp_out(ABC_D, IV_C)); end
        take_digest();
    endtask

    task automatic test_back_to_back();
        int n;
        int w;
        logic overlap;
        logic seen_idle;
        overlap   = 1'b0;
        seen_idle = 1'b0;
        bus_if.block_in  = EMPTY_B;
        bus_if.h_in      = IV_C;
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b1;
        w = 0;
        while (bus_if.busy !== 1'b1 && w < 10) begin @(posedge clk); #1; w++; end
        n = 0;
        while (!(seen_idle && bus_if.busy === 1'b1) && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (bus_if.busy === 1'b0) seen_idle = 1'b1;
            if (bus_if.in_ready === 1'b1 && bus_if.out_valid === 1'b1) overlap = 1'b1;
        end
        bus_if.in_valid = 1'b0;
        total++; if (n !== LAT_EXP + 2) begin bad++; $display("FAIL b2b_period got=%0d exp=%0d", n, LAT_EXP + 2); end
        total++; if (overlap !== 1'b0) begin bad++; $display("FAIL b2b_ready_valid_overlap got=%b exp=0", overlap); end
        w = 0;
        while (bus_if.out_valid !== 1'b1 && w < 200) begin @(posedge clk); #1; w++; end
        total++; if (bus_if.digest !== exp_out(EMPTY_D, IV_C)) begin bad++; $display("FAIL b2b_digest got=%h exp=%h", bus_if.digest, exp_out(EMPTY_D, IV_C)); end
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        bus_if.block_in  = '0;
        bus_if.h_in      = '0;
        test_reset();
        test_abc();
        test_empty();
        test_two_block();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
